// File: rtl/rtp_hit_collector.sv
// ============================================================================
// Module   : rtp_hit_collector
// Brief    : Collects RTP hit results into a FIFO and streams them to the host.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rtp_hit_collector #(
    parameter int DEPTH     = 16,
    parameter int DATA_W    = 32,
    parameter int RAY_CNT_W = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [RAY_CNT_W-1:0]  num_rays,
    input  logic                  io_rtp_finish,
    input  logic [DATA_W-1:0]     io_ray_id_triangle,
    input  logic [DATA_W-1:0]     io_hitIndex,
    input  logic [DATA_W-1:0]     io_hitT,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [3*DATA_W-1:0]   out_data,
    output logic                  out_miss,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [RAY_CNT_W-1:0]  rx_count
);

    localparam int                AW      = $clog2(DEPTH);
    localparam logic [DATA_W-1:0] POS_INF = DATA_W'(32'h7F80_0000);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [RAY_CNT_W-1:0]   num_rays_q;
    logic [3*DATA_W-1:0]    mem [DEPTH];
    logic [AW:0]            wr_ptr;
    logic [AW:0]            rd_ptr;
    logic [AW:0]            wr_nxt;
    logic [AW:0]            rd_nxt;
    logic [3*DATA_W-1:0]    in_data;
    logic [3*DATA_W-1:0]    head_nxt;
    logic                   accept;
    logic                   full;
    logic                   pop;
    logic                   push;
    logic                   start_ok;

    assign in_data  = {io_ray_id_triangle, io_hitIndex, io_hitT};
    assign accept   = io_rtp_finish && (state == COLLECT);
    assign start_ok = start && ((state == IDLE) || (state == DONE));
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop      = out_valid && out_ready;
    assign push     = accept && (!full || pop);
    assign wr_nxt   = wr_ptr + (AW+1)'(push);
    assign rd_nxt   = rd_ptr + (AW+1)'(pop);

    // Output register mirrors the FIFO head; a push into an empty slot bypasses memory.
    assign head_nxt = (push && (rd_nxt[AW-1:0] == wr_ptr[AW-1:0])) ? in_data
                                                                   : mem[rd_nxt[AW-1:0]];

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= in_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_miss   <= 1'b0;
            overflow   <= 1'b0;
            rx_count   <= '0;
            num_rays_q <= '0;
        end else begin
            state     <= state_nxt;
            wr_ptr    <= wr_nxt;
            rd_ptr    <= rd_nxt;
            out_valid <= (wr_nxt != rd_nxt);
            if (wr_nxt != rd_nxt) begin
                out_data <= head_nxt;
                out_miss <= (head_nxt[DATA_W-1:0] == POS_INF);
            end
            if (start_ok) begin
                rx_count   <= '0;
                overflow   <= 1'b0;
                num_rays_q <= num_rays;
            end else if (accept) begin
                rx_count <= rx_count + 1'b1;
                if (full && !pop) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = (num_rays == '0) ? DONE : COLLECT;
                end
            end
            COLLECT: begin
                if ((rx_count + RAY_CNT_W'(io_rtp_finish)) == num_rays_q) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (!out_valid) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == COLLECT) || (state == DRAIN);
    assign done = (state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_rtp_hit_collector.sv
// ============================================================================
// Module   : tb_rtp_hit_collector
// Brief    : Directed self-checking bench for rtp_hit_collector.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rtp_hit_collector;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [15:0]  num_rays;
    logic         io_rtp_finish;
    logic [31:0]  io_ray_id_triangle;
    logic [31:0]  io_hitIndex;
    logic [31:0]  io_hitT;
    logic         out_valid;
    logic         out_ready;
    logic [95:0]  out_data;
    logic         out_miss;
    logic         busy;
    logic         done;
    logic         overflow;
    logic [15:0]  rx_count;

    int n_assert = 0;
    int n_fail   = 0;

    rtp_hit_collector #(.DEPTH(16), .DATA_W(32), .RAY_CNT_W(16)) dut (
        .clock              (clock),
        .reset              (reset),
        .start              (start),
        .num_rays           (num_rays),
        .io_rtp_finish      (io_rtp_finish),
        .io_ray_id_triangle (io_ray_id_triangle),
        .io_hitIndex        (io_hitIndex),
        .io_hitT            (io_hitT),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_data           (out_data),
        .out_miss           (out_miss),
        .busy               (busy),
        .done               (done),
        .overflow           (overflow),
        .rx_count           (rx_count)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [95:0] mk(input int k);
        return {32'(k), 32'(k) ^ 32'hA5A5_0000, 32'h4000_0000 + 32'(k)};
    endfunction

    task automatic drive(input logic [95:0] d);
        io_ray_id_triangle = d[95:64];
        io_hitIndex        = d[63:32];
        io_hitT            = d[31:0];
    endtask

    task automatic begin_frame(input int n);
        num_rays = 16'(n);
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (done) break;
            tick();
        end
        check(tag, 128'(done), 128'd1);
    endtask

    // Pops with out_ready held high, checking arrival order from entry 'base'.
    task automatic drain_check(input string tag, input int n_exp, input int base);
        int pops = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 80; i++) begin
            if (done) break;
            if (out_valid) begin
                check(tag, 128'(out_data), 128'(mk(base + pops)));
                pops++;
            end
            tick();
        end
        check({tag, "_pops"}, 128'(pops), 128'(n_exp));
        check({tag, "_done"}, 128'(done), 128'd1);
    endtask

    initial begin
        logic [95:0] d;
        logic [95:0] held;
        logic        stalled;
        int          sent;
        int          got;

        reset = 1'b1; start = 1'b0; num_rays = '0; io_rtp_finish = 1'b0;
        out_ready = 1'b0; drive('0);
        tick(); tick();
        check("rst_valid", 128'(out_valid), 128'd0);
        check("rst_data",  128'(out_data),  128'd0);
        check("rst_miss",  128'(out_miss),  128'd0);
        check("rst_busy",  128'(busy),      128'd0);
        check("rst_done",  128'(done),      128'd0);
        check("rst_ovf",   128'(overflow),  128'd0);
        check("rst_cnt",   128'(rx_count),  128'd0);
        reset = 1'b0;
        tick();

        // Three spaced results, consumer always ready; middle one is a miss.
        out_ready = 1'b1;
        begin_frame(3);
        check("t1_busy", 128'(busy), 128'd1);
        for (int i = 0; i < 3; i++) begin
            d = mk(10 + i);
            if (i == 1) d[31:0] = 32'h7F80_0000;
            drive(d);
            io_rtp_finish = 1'b1;
            tick();
            io_rtp_finish = 1'b0;
            check("t1_valid", 128'(out_valid), 128'd1);
            check("t1_data",  128'(out_data),  128'(d));
            check("t1_miss",  128'(out_miss),  128'(i == 1));
            tick();
            check("t1_popped", 128'(out_valid), 128'd0);
        end
        check("t1_cnt", 128'(rx_count), 128'd3);
        wait_done("t1_done", 10);
        check("t1_notbusy", 128'(busy), 128'd0);

        // Overflow: 18 results into a 16-deep FIFO with the consumer stalled.
        out_ready = 1'b0;
        begin_frame(18);
        for (int k = 0; k < 18; k++) begin
            drive(mk(100 + k));
            io_rtp_finish = 1'b1;
            tick();
        end
        io_rtp_finish = 1'b0;
        check("t2_cnt",   128'(rx_count), 128'd18);
        check("t2_ovf",   128'(overflow), 128'd1);
        check("t2_valid", 128'(out_valid), 128'd1);
        check("t2_head",  128'(out_data), 128'(mk(100)));
        tick();
        check("t2_stall", 128'(out_data), 128'(mk(100)));
        drain_check("t2_drain", 16, 100);

        // Full FIFO, push coincides with a pop: the push is accepted.
        out_ready = 1'b0;
        begin_frame(17);
        check("t3_ovf_clr", 128'(overflow), 128'd0);
        for (int k = 0; k < 16; k++) begin
            drive(mk(200 + k));
            io_rtp_finish = 1'b1;
            tick();
        end
        io_rtp_finish = 1'b0;
        tick();
        check("t3_full_ovf", 128'(overflow), 128'd0);
        check("t3_head", 128'(out_data), 128'(mk(200)));
        drive(mk(216));
        io_rtp_finish = 1'b1;
        out_ready = 1'b1;
        tick();
        io_rtp_finish = 1'b0;
        check("t3_ovf", 128'(overflow), 128'd0);
        check("t3_cnt", 128'(rx_count), 128'd17);
        drain_check("t3_drain", 16, 201);

        // 100 results with random back-pressure.
        sent = 0; got = 0; stalled = 1'b0; held = '0;
        begin_frame(100);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (done) break;
            if (stalled) check("t4_stable", 128'(out_data), 128'(held));
            out_ready = 1'($urandom_range(0, 1));
            io_rtp_finish = 1'b0;
            if (sent < 100 && $urandom_range(0, 2) == 0) begin
                drive(mk(300 + sent));
                io_rtp_finish = 1'b1;
                sent++;
            end
            if (out_valid && out_ready) begin
                check("t4_data", 128'(out_data), 128'(mk(300 + got)));
                got++;
            end
            stalled = out_valid && !out_ready;
            held    = out_data;
            tick();
        end
        io_rtp_finish = 1'b0;
        check("t4_got",  128'(got),      128'd100);
        check("t4_ovf",  128'(overflow), 128'd0);
        check("t4_cnt",  128'(rx_count), 128'd100);
        check("t4_done", 128'(done),     128'd1);

        // Reset mid-frame, finish while idle, then an empty frame.
        out_ready = 1'b0;
        begin_frame(10);
        for (int k = 0; k < 5; k++) begin
            drive(mk(400 + k));
            io_rtp_finish = 1'b1;
            tick();
        end
        io_rtp_finish = 1'b0;
        check("t5_queued", 128'(out_valid), 128'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_valid", 128'(out_valid), 128'd0);
        check("t5_busy",  128'(busy),      128'd0);
        check("t5_done",  128'(done),      128'd0);
        check("t5_cnt",   128'(rx_count),  128'd0);
        drive(mk(500));
        io_rtp_finish = 1'b1;
        tick();
        io_rtp_finish = 1'b0;
        tick();
        check("t5_idle_valid", 128'(out_valid), 128'd0);
        check("t5_idle_cnt",   128'(rx_count),  128'd0);
        begin_frame(0);
        check("t5_zero_done", 128'(done), 128'd1);
        check("t5_zero_busy", 128'(busy), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
